// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: iterative multiply/divide sequencer that owns the HI/LO pair.
// A multiply is done by shift-add and a divide by restoring division.
// Each takes WIDTH iterations in CALC and then one DONE cycle that writes HI/LO.
// Optional feature: define MULDIV_SIGNED_EN to make op_sel 10/11 signed MULT/DIV.
// Without it, op_sel[1] is ignored.
module muldiv_ctrl #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             op_valid,
   input  logic [1:0]       op_sel,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  logic             mf_req,
   input  logic             hi_we,
   input  logic             lo_we,
   input  logic [WIDTH-1:0] mt_data,
   input  logic             kill,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             busy,
   output logic             done,
   output logic             stall
);

   localparam logic [1:0] S_IDLE = 2'b00;
   localparam logic [1:0] S_CALC = 2'b01;
   localparam logic [1:0] S_DONE = 2'b10;

   // Sequencer state and iteration counter
   logic [1:0]       state_reg;
   logic [CNT_W-1:0] cnt_reg;

   // Shared datapath registers.
   // Multiply: acc_hi:acc_lo is the product register, acc_lo starts as the
   //           multiplier, and opnd holds the multiplicand.
   // Divide:   acc_hi is the partial remainder, acc_lo starts as the dividend
   //           and fills with quotient bits, and opnd holds the divisor.
   // Either way, acc_hi/acc_lo end up as the raw hi/lo result.
   logic [WIDTH-1:0] acc_hi_reg;
   logic [WIDTH-1:0] acc_lo_reg;
   logic [WIDTH-1:0] opnd_reg;
   logic             is_div_reg;

   // Architectural HI/LO
   logic [WIDTH-1:0] hi_reg;
   logic [WIDTH-1:0] lo_reg;

   // Combinational helpers
   logic             accept;
   logic [WIDTH-1:0] mag_a;
   logic [WIDTH-1:0] mag_b;
   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   rem_shift;
   logic [WIDTH+1:0] diff;
   logic             qbit;
   logic [WIDTH-1:0] step_hi;
   logic [WIDTH-1:0] step_lo;
   logic [WIDTH-1:0] res_hi;
   logic [WIDTH-1:0] res_lo;

   // An op is taken only from IDLE and only if it is not being flushed.
   assign accept = (state_reg == S_IDLE) && op_valid && !kill;

`ifdef MULDIV_SIGNED_EN
   // Sign bookkeeping for signed ops.
   // neg_q gives the sign of the product or quotient.
   // neg_r gives the sign of the remainder, which follows the dividend.
   logic neg_q_reg;
   logic neg_r_reg;
   logic unused_bits;

   // Signed ops iterate on operand magnitudes.
   always_comb begin
      mag_a = op_a;
      mag_b = op_b;
      if (op_sel[1] && op_a[WIDTH-1]) mag_a = -op_a;
      if (op_sel[1] && op_b[WIDTH-1]) mag_b = -op_b;
   end

   // Capture the result signs when the op is accepted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         neg_q_reg <= 1'b0;
         neg_r_reg <= 1'b0;
      end else if (accept) begin
         neg_q_reg <= op_sel[1] & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
         neg_r_reg <= op_sel[1] & op_a[WIDTH-1];
      end
   end

   // Re-apply signs to the unsigned result in DONE.
   // A signed divide by zero naturally yields lo=(a<0 ? 1 : all ones) and hi=a.
   always_comb begin
      res_hi = acc_hi_reg;
      res_lo = acc_lo_reg;
      if (is_div_reg) begin
         if (neg_q_reg) res_lo = -acc_lo_reg;
         if (neg_r_reg) res_hi = -acc_hi_reg;
      end else if (neg_q_reg) begin
         {res_hi, res_lo} = -{acc_hi_reg, acc_lo_reg};
      end
   end

   // Bit W of the trial difference is never needed, because a successful
   // subtraction always fits in W bits.
   assign unused_bits = diff[WIDTH];
`else
   logic [1:0] unused_bits;

   // Unsigned only: operands pass straight through and the result needs no fix-up.
   assign mag_a  = op_a;
   assign mag_b  = op_b;
   assign res_hi = acc_hi_reg;
   assign res_lo = acc_lo_reg;

   // op_sel[1] has no meaning without signed support.
   assign unused_bits = {op_sel[1], diff[WIDTH]};
`endif

   // One iteration step for either operation.
   // With a zero divisor, every trial subtraction succeeds.
   // That gives a quotient of all ones and a remainder equal to the dividend.
   always_comb begin
      sum       = {1'b0, acc_hi_reg} + (acc_lo_reg[0] ? {1'b0, opnd_reg} : '0);
      rem_shift = {acc_hi_reg, acc_lo_reg[WIDTH-1]};
      diff      = {1'b0, rem_shift} - {2'b00, opnd_reg};
      qbit      = ~diff[WIDTH+1];
      if (is_div_reg) begin
         step_hi = qbit ? diff[WIDTH-1:0] : rem_shift[WIDTH-1:0];
         step_lo = {acc_lo_reg[WIDTH-2:0], qbit};
      end else begin
         step_hi = sum[WIDTH:1];
         step_lo = {sum[0], acc_lo_reg[WIDTH-1:1]};
      end
   end

   // Sequencer: IDLE -> CALC (WIDTH iterations) -> DONE -> IDLE.
   // A kill during CALC aborts the op.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg  <= S_IDLE;
         cnt_reg    <= '0;
         acc_hi_reg <= '0;
         acc_lo_reg <= '0;
         opnd_reg   <= '0;
         is_div_reg <= 1'b0;
      end else begin
         case (state_reg)
            S_IDLE: begin
               if (accept) begin
                  state_reg  <= S_CALC;
                  cnt_reg    <= '0;
                  is_div_reg <= op_sel[0];
                  acc_hi_reg <= '0;
                  acc_lo_reg <= op_sel[0] ? mag_a : mag_b;
                  opnd_reg   <= op_sel[0] ? mag_b : mag_a;
               end
            end
            S_CALC: begin
               if (kill) begin
                  state_reg <= S_IDLE;
               end else begin
                  acc_hi_reg <= step_hi;
                  acc_lo_reg <= step_lo;
                  cnt_reg    <= cnt_reg + 1'b1;
                  if (cnt_reg == CNT_W'(WIDTH - 1)) state_reg <= S_DONE;
               end
            end
            S_DONE: begin
               state_reg <= S_IDLE;
            end
            default: begin
               state_reg <= S_IDLE;
            end
         endcase
      end
   end

   // HI/LO writes.
   // In DONE the op result is written.
   // In IDLE, MTHI/MTLO write mt_data; this also happens alongside an accepted op,
   // whose result later overwrites it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hi_reg <= '0;
         lo_reg <= '0;
      end else if (state_reg == S_DONE) begin
         hi_reg <= res_hi;
         lo_reg <= res_lo;
      end else if (state_reg == S_IDLE) begin
         if (hi_we) hi_reg <= mt_data;
         if (lo_we) lo_reg <= mt_data;
      end
   end

   assign hi    = hi_reg;
   assign lo    = lo_reg;
   assign busy  = (state_reg == S_CALC) || (state_reg == S_DONE);
   assign done  = (state_reg == S_DONE);
   assign stall = busy & (op_valid | mf_req | hi_we | lo_we);

endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb_muldiv_ctrl: self-checking bench for muldiv_ctrl (WIDTH=32).
// A vector table is run through a scoreboard queue.
// Hand-written sequences cover stall, kill, move/op overlap and async reset.
module tb_muldiv_ctrl;

   localparam int W = 32;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          op_valid;
   logic [1:0]    op_sel;
   logic [W-1:0]  op_a;
   logic [W-1:0]  op_b;
   logic          mf_req;
   logic          hi_we;
   logic          lo_we;
   logic [W-1:0]  mt_data;
   logic          kill;
   logic [W-1:0]  hi;
   logic [W-1:0]  lo;
   logic          busy;
   logic          done;
   logic          stall;

   muldiv_ctrl #(.WIDTH(W), .CNT_W(6)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .op_valid (op_valid),
      .op_sel   (op_sel),
      .op_a     (op_a),
      .op_b     (op_b),
      .mf_req   (mf_req),
      .hi_we    (hi_we),
      .lo_we    (lo_we),
      .mt_data  (mt_data),
      .kill     (kill),
      .hi       (hi),
      .lo       (lo),
      .busy     (busy),
      .done     (done),
      .stall    (stall)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  sel;
      logic [31:0] a;
      logic [31:0] b;
      logic [63:0] exp;
   } vec_t;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
   } exp_t;

   exp_t sb_q[$];
   vec_t vecs[14];
   int   checks = 0;
   int   errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference result {hi, lo} computed with plain operators.
   function automatic logic [63:0] ref_model(input logic [1:0] sel, input logic [31:0] a,
                                             input logic [31:0] b);
      logic [63:0] r;
`ifdef MULDIV_SIGNED_EN
      if (sel[1]) begin
         logic signed [63:0] sa;
         logic signed [63:0] sb;
         logic signed [31:0] q;
         logic signed [31:0] m;
         sa = {{32{a[31]}}, a};
         sb = {{32{b[31]}}, b};
         if (!sel[0]) r = sa * sb;
         else if (b == 32'h0) r = {a, (a[31] ? 32'h1 : 32'hFFFFFFFF)};
         else begin
            q = $signed(a) / $signed(b);
            m = $signed(a) % $signed(b);
            r = {m, q};
         end
         return r;
      end
`endif
      if (!sel[0]) r = {32'h0, a} * {32'h0, b};
      else if (b == 32'h0) r = {a, 32'hFFFFFFFF};
      else r = {a % b, a / b};
      return r;
   endfunction

   // Drive an op for one accept edge.
   // When push is set, the expected result goes on the scoreboard.
   task automatic issue(input logic [1:0] sel, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp, input bit push);
      exp_t e;
      e.hi = exp[63:32];
      e.lo = exp[31:0];
      if (push) sb_q.push_back(e);
      op_valid = 1'b1;
      op_sel   = sel;
      op_a     = a;
      op_b     = b;
      tick();
      op_valid = 1'b0;
   endtask

   // Follow an accepted op to IDLE and check stall, done count, busy length and result.
   // mf_req is raised from cycle mf_at onward (negative = never).
   task automatic finish_op(input string name, input int mf_at);
      int   cyc  = 0;
      int   dcnt = 0;
      bit   got  = 0;
      exp_t e;
      e.hi = '0;
      e.lo = '0;
      while (busy === 1'b1 && cyc < 200) begin
         mf_req = (mf_at >= 0 && cyc >= mf_at);
         #1;
         check({name, " stall"}, 64'(stall), 64'(mf_req));
         if (done === 1'b1) begin
            dcnt++;
            if (sb_q.size() > 0 && !got) begin
               e   = sb_q.pop_front();
               got = 1;
            end
         end
         tick();
         cyc++;
      end
      if (!got && sb_q.size() > 0) e = sb_q.pop_front();
      check({name, " done pulses"}, 64'(dcnt), 64'd1);
      check({name, " busy cycles"}, 64'(cyc), 64'(W + 1));
      check({name, " hi"}, 64'(hi), 64'(e.hi));
      check({name, " lo"}, 64'(lo), 64'(e.lo));
      if (mf_at >= 0) begin
         #1;
         check({name, " stall after done"}, 64'(stall), 64'd0);
      end
      mf_req = 1'b0;
      $display("OP %s sel=%b a=%h b=%h -> hi=%h lo=%h cycles=%0d", name, op_sel, op_a, op_b,
               hi, lo, cyc);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int dn;
      logic [31:0] ra;
      logic [31:0] rb;
      logic [1:0]  rs;

      op_valid = 0; op_sel = 0; op_a = 0; op_b = 0; mf_req = 0;
      hi_we = 0; lo_we = 0; mt_data = 0; kill = 0; rst_n = 0;

      vecs[0] = '{2'b00, 32'hFFFFFFFF, 32'h00000002, 64'h00000001_FFFFFFFE};
      vecs[1] = '{2'b01, 32'd100,      32'd7,        64'h00000002_0000000E};
      vecs[2] = '{2'b01, 32'h00001234, 32'h0,        64'h00001234_FFFFFFFF};
      vecs[3] = '{2'b01, 32'd7,        32'd100,      64'h00000007_00000000};
      vecs[4] = '{2'b00, 32'h0,        32'hDEADBEEF, 64'h0};
      vecs[5] = '{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001};
      vecs[6] = '{2'b01, 32'hFFFFFFFF, 32'h1,        64'h00000000_FFFFFFFF};
`ifdef MULDIV_SIGNED_EN
      vecs[7] = '{2'b10, 32'hFFFFFFFD, 32'd5,        64'hFFFFFFFF_FFFFFFF1};
      vecs[8] = '{2'b11, 32'hFFFFFFF9, 32'd2,        64'hFFFFFFFF_FFFFFFFD};
      vecs[9] = '{2'b11, 32'hFFFFFFF9, 32'h0,        64'hFFFFFFF9_00000001};
`else
      vecs[7] = '{2'b10, 32'hFFFFFFFD, 32'd5,        64'h00000004_FFFFFFF1};
      vecs[8] = '{2'b11, 32'hFFFFFFF9, 32'd2,        64'h00000001_7FFFFFFC};
      vecs[9] = '{2'b11, 32'hFFFFFFF9, 32'h0,        64'hFFFFFFF9_FFFFFFFF};
`endif
      for (int i = 10; i < 14; i++) begin
         ra = $urandom;
         rb = $urandom;
         rs = 2'($urandom_range(0, 3));
         if (i == 13) rb = 32'h0000_00F3;
         if (ra == 32'h80000000 && rb == 32'hFFFFFFFF) rb = 32'h1;
         vecs[i] = '{rs, ra, rb, ref_model(rs, ra, rb)};
      end

      // Reset state, with a pending request that must not stall.
      op_valid = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("reset hi", 64'(hi), 64'd0);
      check("reset lo", 64'(lo), 64'd0);
      check("reset busy", 64'(busy), 64'd0);
      check("reset done", 64'(done), 64'd0);
      check("reset stall", 64'(stall), 64'd0);
      op_valid = 1'b0;
      rst_n = 1'b1;
      tick();

      // Table-driven ops.
      for (int i = 0; i < 14; i++) begin
         issue(vecs[i].sel, vecs[i].a, vecs[i].b, vecs[i].exp, 1'b1);
         finish_op($sformatf("vec%0d", i), -1);
      end

      // mf_req in IDLE reads HI/LO directly with no stall.
      mf_req = 1'b1;
      #1;
      check("idle mf stall", 64'(stall), 64'd0);
      check("idle mf hi", 64'(hi), 64'(vecs[13].exp[63:32]));
      mf_req = 1'b0;
      tick();

      // mf_req raised 5 cycles after a MULTU is accepted.
      issue(2'b00, 32'hFFFFFFFF, 32'h2, 64'h00000001_FFFFFFFE, 1'b1);
      finish_op("mf_stall", 5);

      // A flushed op in IDLE is not accepted.
      op_valid = 1'b1; kill = 1'b1; op_sel = 2'b00; op_a = 32'h5; op_b = 32'h5;
      tick();
      op_valid = 1'b0; kill = 1'b0;
      check("idle kill busy", 64'(busy), 64'd0);

      // MTHI then MTLO in IDLE.
      hi_we = 1'b1; mt_data = 32'hA;
      tick();
      hi_we = 1'b0; lo_we = 1'b1; mt_data = 32'hB;
      tick();
      lo_we = 1'b0;
      check("mthi", 64'(hi), 64'hA);
      check("mtlo", 64'(lo), 64'hB);
      $display("OP moves hi=%h lo=%h", hi, lo);

      // A kill in CALC cycle 10 aborts the op: HI/LO are kept and no done pulse occurs.
      issue(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'h0, 1'b0);
      repeat (10) tick();
      kill = 1'b1;
      tick();
      kill = 1'b0;
      check("kill busy", 64'(busy), 64'd0);
      check("kill hi", 64'(hi), 64'hA);
      check("kill lo", 64'(lo), 64'hB);
      dn = 0;
      for (int i = 0; i < 40; i++) begin
         if (done === 1'b1) dn++;
         tick();
      end
      check("kill no done", 64'(dn), 64'd0);
      check("kill hi later", 64'(hi), 64'hA);
      $display("OP kill hi=%h lo=%h", hi, lo);

      // A move together with an op: the move lands now, and the op result overwrites it.
      hi_we = 1'b1; mt_data = 32'h55;
      issue(2'b00, 32'd3, 32'd4, 64'h00000000_0000000C, 1'b1);
      hi_we = 1'b0;
      check("move with op hi", 64'(hi), 64'h55);
      finish_op("move_op", -1);

      // An asynchronous reset in the middle of CALC clears state before the next edge.
      issue(2'b00, 32'hFFFFFFFF, 32'h2, 64'h0, 1'b0);
      check("pre-reset hi nonzero", 64'(hi != 32'h0 || lo != 32'h0), 64'd1);
      repeat (3) tick();
      #2;
      rst_n = 1'b0;
      #1;
      check("async rst hi", 64'(hi), 64'd0);
      check("async rst lo", 64'(lo), 64'd0);
      check("async rst busy", 64'(busy), 64'd0);
      check("async rst stall", 64'(stall), 64'd0);
      tick();
      rst_n = 1'b1;
      repeat (40) tick();
      check("post rst hi", 64'(hi), 64'd0);
      check("post rst lo", 64'(lo), 64'd0);
      check("post rst busy", 64'(busy), 64'd0);
      $display("OP reset hi=%h lo=%h", hi, lo);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
